// File: rtl/hmnoc_router_node.sv
// Circuit-switched 5-port HM-NoC router node: input FIFOs, run-time routing table, atomic multicast.
// Optional per-output delivered-flit counters are enabled with the macro ROUTER_PERF_CNT_EN.
module hmnoc_router_node #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data   [5],
    input  logic [4:0]            in_valid,
    output logic [4:0]            in_ready,
    output logic [DATA_WIDTH-1:0] out_data  [5],
    output logic [4:0]            out_valid,
    input  logic [4:0]            out_ready,
    input  logic                  cfg_we,
    input  logic [2:0]            cfg_port,
    input  logic [2:0]            cfg_src,
    input  logic                  cnt_clr,
    output logic [CNT_WIDTH-1:0]  flit_cnt  [5]
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [5][FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr [5];
    logic [PW-1:0]         rd_ptr [5];
    logic [2:0]            sel [5];

    logic [4:0]            empty;
    logic [4:0]            full;
    logic [4:0]            push;
    logic [4:0]            fwd;
    logic [4:0]            slot_free;
    logic [4:0]            load;
    logic [4:0]            cons [5];
    logic [DATA_WIDTH-1:0] head [5];
    logic [DATA_WIDTH-1:0] load_data [5];

    always_comb begin
        empty = '0;
        full  = '0;
        for (int i = 0; i < 5; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                       (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
            head[i]  = mem[i][rd_ptr[i][AW-1:0]];
        end
    end

    assign in_ready  = reset ? 5'b00000 : ~full;
    assign push      = in_valid & in_ready;
    assign slot_free = ~out_valid | out_ready;

    // cons[i][o]: output o takes input i; a U-turn or a source code of 5..7 never matches.
    always_comb begin
        fwd  = '0;
        load = '0;
        for (int i = 0; i < 5; i++) begin
            cons[i] = '0;
            for (int o = 0; o < 5; o++) begin
                cons[i][o] = (sel[o] == 3'(i)) && (i != o);
            end
        end
        for (int o = 0; o < 5; o++) begin
            load_data[o] = '0;
        end
        for (int i = 0; i < 5; i++) begin
            fwd[i] = !empty[i] && (|cons[i]) && ((cons[i] & ~slot_free) == 5'b00000);
            for (int o = 0; o < 5; o++) begin
                if (fwd[i] && cons[i][o]) begin
                    load[o]      = 1'b1;
                    load_data[o] = head[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i][AW-1:0]] <= in_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (fwd[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int o = 0; o < 5; o++) begin
                sel[o] <= 3'd7;
            end
        end else if (cfg_we) begin
            for (int o = 0; o < 5; o++) begin
                if (cfg_port == 3'(o)) begin
                    sel[o] <= cfg_src;
                end
            end
        end
    end

    // A held (blocked) slot keeps its data and valid; a free slot either reloads or empties.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= '0;
            for (int o = 0; o < 5; o++) begin
                out_data[o] <= '0;
            end
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (load[o]) begin
                    out_valid[o] <= 1'b1;
                    out_data[o]  <= load_data[o];
                end else if (slot_free[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
        end
    end

`ifdef ROUTER_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] cnt [5];

    always_ff @(posedge clk) begin
        for (int o = 0; o < 5; o++) begin
            if (reset || cnt_clr) begin
                cnt[o] <= '0;
            end else if (out_valid[o] && out_ready[o]) begin
                cnt[o] <= cnt[o] + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        for (int o = 0; o < 5; o++) begin
            flit_cnt[o] = cnt[o];
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;

    always_comb begin
        for (int o = 0; o < 5; o++) begin
            flit_cnt[o] = '0;
        end
    end
`endif

endmodule

// File: tb/tb_hmnoc_router_node.sv
// Table-driven bench for hmnoc_router_node, plus a hand-written counter sequence.
module tb_hmnoc_router_node;

    localparam int DW = 16;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data  [5];
    logic [4:0]    in_valid;
    logic [4:0]    in_ready;
    logic [DW-1:0] out_data [5];
    logic [4:0]    out_valid;
    logic [4:0]    out_ready;
    logic          cfg_we;
    logic [2:0]    cfg_port;
    logic [2:0]    cfg_src;
    logic          cnt_clr;
    logic [CW-1:0] flit_cnt [5];

    always #5 clk = ~clk;

    hmnoc_router_node #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cfg_we    (cfg_we),
        .cfg_port  (cfg_port),
        .cfg_src   (cfg_src),
        .cnt_clr   (cnt_clr),
        .flit_cnt  (flit_cnt)
    );

    typedef struct {
        logic          rst;
        logic          we;
        logic [2:0]    port;
        logic [2:0]    src;
        logic [4:0]    pmask;
        logic [15:0]   pdata;
        logic [4:0]    ordy;
        logic [4:0]    exp_ov;
        logic [2:0]    chk;
        logic [15:0]   exp_od;
        logic [4:0]    exp_ir;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   passes = 0;

    localparam logic [4:0] ALL = 5'b11111;
    localparam logic [4:0] PN = 5'b00001, PS = 5'b00010, PW = 5'b00100, PE = 5'b01000, PL = 5'b10000;

    function automatic vec_t mk(input logic rst, input logic we, input logic [2:0] port,
                                input logic [2:0] src, input logic [4:0] pmask,
                                input logic [15:0] pdata, input logic [4:0] ordy,
                                input logic [4:0] exp_ov, input logic [2:0] chk,
                                input logic [15:0] exp_od, input logic [4:0] exp_ir);
        vec_t v;
        v.rst = rst; v.we = we; v.port = port; v.src = src; v.pmask = pmask;
        v.pdata = pdata; v.ordy = ordy; v.exp_ov = exp_ov; v.chk = chk;
        v.exp_od = exp_od; v.exp_ir = exp_ir;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic apply_stimulus(input vec_t v);
        reset    = v.rst;
        cfg_we   = v.we;
        cfg_port = v.port;
        cfg_src  = v.src;
        in_valid = v.pmask;
        for (int p = 0; p < 5; p++) in_data[p] = v.pdata;
        out_ready = v.ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input int idx, input vec_t v);
        check($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'(v.exp_ov));
        if (v.chk < 3'd5)
            check($sformatf("v%0d out_data[%0d]", idx, v.chk), 32'(out_data[v.chk]), 32'(v.exp_od));
        check($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'(v.exp_ir));
    endtask

    initial begin
        logic [CW-1:0] exp_cnt10;
`ifdef ROUTER_PERF_CNT_EN
        exp_cnt10 = 10;
`else
        exp_cnt10 = 0;
`endif
        cnt_clr = 1'b0;

        // reset and unicast W -> E
        tbl.push_back(mk(1, 0, 0, 0, 0,  16'h0000, ALL, 5'b00000, 7, 16'h0000, 5'b00000));
        tbl.push_back(mk(0, 0, 0, 0, 0,  16'h0000, ALL, 5'b00000, 7, 16'h0000, ALL));
        tbl.push_back(mk(0, 1, 3, 2, 0,  16'h0000, ALL, 5'b00000, 7, 16'h0000, ALL));
        tbl.push_back(mk(0, 0, 0, 0, PW, 16'h0011, ALL, 5'b00000, 7, 16'h0000, ALL));
        tbl.push_back(mk(0, 0, 0, 0, PW, 16'h0022, ALL, PE,       3, 16'h0011, ALL));
        tbl.push_back(mk(0, 0, 0, 0, PW, 16'h0033, ALL, PE,       3, 16'h0022, ALL));
        tbl.push_back(mk(0, 0, 0, 0, 0,  16'h0000, ALL, PE,       3, 16'h0033, ALL));
        tbl.push_back(mk(0, 0, 0, 0, 0,  16'h0000, ALL, 5'b00000, 7, 16'h0000, ALL));
        // multicast S -> {N, L} with L stalled
        tbl.push_back(mk(0, 1, 0, 1, 0,  16'h0000, ALL,      5'b00000, 7, 16'h0000, ALL));
        tbl.push_back(mk(0, 1, 4, 1, 0,  16'h0000, 5'b01111, 5'b00000, 7, 16'h0000, ALL));
        tbl.push_back(mk(0, 0, 0, 0, PS, 16'h00AA, 5'b01111, 5'b00000, 7, 16'h0000, ALL));
        tbl.push_back(mk(0, 0, 0, 0, PS, 16'h00BB, 5'b01111, PN | PL,  0, 16'h00AA, ALL));
        tbl.push_back(mk(0, 0, 0, 0, 0,  16'h0000, 5'b01111, PL,       4, 16'h00AA, ALL));
        tbl.push_back(mk(0, 0, 0, 0, 0,  16'h0000, 5'b01111, PL,       4, 16'h00AA, ALL));
        tbl.push_back(mk(0, 0, 0, 0, 0,  16'h0000, ALL,      PN | PL,  0, 16'h00BB, ALL));
        tbl.push_back(mk(0, 0, 0, 0, 0,  16'h0000, ALL,      5'b00000, 7, 16'h0000, ALL));
        // disabled and U-turn routes
        tbl.push_back(mk(0, 1, 0, 7, 0,  16'h0000, ALL, 5'b00000, 7, 16'h0000, ALL));
        tbl.push_back(mk(0, 1, 4, 5, 0,  16'h0000, ALL, 5'b00000, 7, 16'h0000, ALL));
        tbl.push_back(mk(0, 1, 3, 3, 0,  16'h0000, ALL, 5'b00000, 7, 16'h0000, ALL));
        tbl.push_back(mk(0, 1, 2, 6, 0,  16'h0000, ALL, 5'b00000, 7, 16'h0000, ALL));
        tbl.push_back(mk(0, 0, 0, 0, PE, 16'h0044, ALL, 5'b00000, 7, 16'h0000, ALL));
        tbl.push_back(mk(0, 0, 0, 0, 0,  16'h0000, ALL, 5'b00000, 7, 16'h0000, ALL));
        // backpressure: fill W, then route W -> S
        tbl.push_back(mk(0, 0, 0, 0, PW, 16'h0101, ALL, 5'b00000, 7, 16'h0000, ALL));
        tbl.push_back(mk(0, 0, 0, 0, PW, 16'h0102, ALL, 5'b00000, 7, 16'h0000, ALL));
        tbl.push_back(mk(0, 0, 0, 0, PW, 16'h0103, ALL, 5'b00000, 7, 16'h0000, ALL));
        tbl.push_back(mk(0, 0, 0, 0, PW, 16'h0104, ALL, 5'b00000, 7, 16'h0000, 5'b11011));
        tbl.push_back(mk(0, 0, 0, 0, PW, 16'h0105, ALL, 5'b00000, 7, 16'h0000, 5'b11011));
        tbl.push_back(mk(0, 1, 1, 2, PW, 16'h0105, ALL, 5'b00000, 7, 16'h0000, 5'b11011));
        tbl.push_back(mk(0, 0, 0, 0, PW, 16'h0105, ALL, PS,       1, 16'h0101, ALL));
        tbl.push_back(mk(0, 0, 0, 0, PW, 16'h0105, ALL, PS,       1, 16'h0102, ALL));
        tbl.push_back(mk(0, 0, 0, 0, 0,  16'h0000, ALL, PS,       1, 16'h0103, ALL));
        tbl.push_back(mk(0, 0, 0, 0, 0,  16'h0000, ALL, PS,       1, 16'h0104, ALL));
        tbl.push_back(mk(0, 0, 0, 0, 0,  16'h0000, ALL, PS,       1, 16'h0105, ALL));
        tbl.push_back(mk(0, 0, 0, 0, 0,  16'h0000, ALL, 5'b00000, 7, 16'h0000, ALL));
        // mid-stream reset with N queued and E slot held
        tbl.push_back(mk(0, 1, 3, 1, 0,       16'h0000, 5'b10111, 5'b00000, 7, 16'h0000, ALL));
        tbl.push_back(mk(0, 0, 0, 0, PN | PS, 16'h0201, 5'b10111, 5'b00000, 7, 16'h0000, ALL));
        tbl.push_back(mk(0, 0, 0, 0, PN,      16'h0202, 5'b10111, PE,       3, 16'h0201, ALL));
        tbl.push_back(mk(0, 0, 0, 0, PN,      16'h0203, 5'b10111, PE,       3, 16'h0201, ALL));
        tbl.push_back(mk(1, 0, 0, 0, 0,       16'h0000, ALL,      5'b00000, 3, 16'h0000, 5'b00000));
        tbl.push_back(mk(0, 0, 0, 0, 0,       16'h0000, ALL,      5'b00000, 7, 16'h0000, ALL));
        tbl.push_back(mk(0, 1, 1, 0, 0,       16'h0000, ALL,      5'b00000, 7, 16'h0000, ALL));
        tbl.push_back(mk(0, 0, 0, 0, 0,       16'h0000, ALL,      5'b00000, 7, 16'h0000, ALL));
        tbl.push_back(mk(0, 1, 0, 3, 0,       16'h0000, ALL,      5'b00000, 7, 16'h0000, ALL));
        tbl.push_back(mk(0, 0, 0, 0, 0,       16'h0000, ALL,      5'b00000, 7, 16'h0000, ALL));
        tbl.push_back(mk(0, 0, 0, 0, PS,      16'h0301, ALL,      5'b00000, 7, 16'h0000, ALL));
        tbl.push_back(mk(0, 0, 0, 0, 0,       16'h0000, ALL,      5'b00000, 7, 16'h0000, ALL));

        for (int k = 0; k < tbl.size(); k++) begin
            apply_stimulus(tbl[k]);
            check_output(k, tbl[k]);
        end

        // counters: 10 deliveries on S, then a clear that coincides with an 11th delivery
        apply_stimulus(mk(1, 0, 0, 0, 0, 16'h0000, ALL, 0, 7, 0, 0));
        check("cnt after reset", flit_cnt[1], 32'd0);
        apply_stimulus(mk(0, 1, 1, 2, 0, 16'h0000, ALL, 0, 7, 0, 0));
        for (int s = 0; s < 12; s++) begin
            apply_stimulus(mk(0, 0, 0, 0, (s < 10) ? PW : 5'b00000, 16'(16'h0401 + s), ALL, 0, 7, 0, 0));
            if (s >= 1 && s <= 10) begin
                check($sformatf("stream%0d valid", s), 32'(out_valid[1]), 32'd1);
                check($sformatf("stream%0d data", s), 32'(out_data[1]), 32'(16'h0400 + s));
            end
        end
        check("cnt after 10", flit_cnt[1], exp_cnt10);
        apply_stimulus(mk(0, 0, 0, 0, PW, 16'h0411, ALL, 0, 7, 0, 0));
        apply_stimulus(mk(0, 0, 0, 0, 0,  16'h0000, ALL, 0, 7, 0, 0));
        check("flit 11 data", 32'(out_data[1]), 32'h0411);
        check("cnt before clr", flit_cnt[1], exp_cnt10);
        cnt_clr = 1'b1;
        apply_stimulus(mk(0, 0, 0, 0, 0, 16'h0000, ALL, 0, 7, 0, 0));
        cnt_clr = 1'b0;
        check("cnt after clr", flit_cnt[1], 32'd0);
        check("S drained", 32'(out_valid), 32'd0);
        apply_stimulus(mk(0, 0, 0, 0, 0, 16'h0000, ALL, 0, 7, 0, 0));
        check("cnt stays 0", flit_cnt[1], 32'd0);
        check("cnt N untouched", flit_cnt[0], 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
